// File: rtl/decode_execute_reg_pkg.sv
// Shared ALU/control package: ALU operation codes, default execute
// latencies for the multi-cycle operations, the execute-stage FSM state
// type, and the packed bundle of decode/execute pipeline fields.
package decode_execute_reg_pkg;

    // ALU operation codes; every other 4-bit value is undefined
    typedef enum logic [3:0] {
        ALU_NOP    = 4'd0,
        ALU_ADD    = 4'd1,
        ALU_SUB    = 4'd2,
        ALU_MULT   = 4'd3,
        ALU_BUFFER = 4'd4,
        ALU_AV     = 4'd5
    } alu_op_e;

    // Default execute-stage occupancy of the multi-cycle operations
    localparam int unsigned MULT_LAT_DEF = 3;
    localparam int unsigned AV_LAT_DEF   = 2;

    // Execute-stage occupancy FSM
    typedef enum logic {
        EX_IDLE  = 1'b0,
        EX_MULTI = 1'b1
    } ex_state_e;

    // Every field carried from decode into execute
    typedef struct packed {
        logic        alu_src;
        logic        mem_to_reg;
        logic        reg_write;
        logic        plus_one;
        logic        branch;
        logic        pc_src;
        logic [3:0]  alu_control;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [31:0] ext_imm;
        logic [3:0]  ra1;
        logic [3:0]  ra2;
        logic [3:0]  wa3;
    } de_fields_t;

    // A bubble is all-zero; ALU_NOP is encoded as zero
    localparam de_fields_t DE_BUBBLE = '0;

    // True for the six defined ALU codes
    function automatic logic alu_op_legal(input logic [3:0] op);
        logic legal;
        case (op)
            ALU_NOP, ALU_ADD, ALU_SUB,
            ALU_MULT, ALU_BUFFER, ALU_AV: legal = 1'b1;
            default:                      legal = 1'b0;
        endcase
        return legal;
    endfunction

    // True for operations that occupy execute for more than one cycle
    function automatic logic alu_op_multi(input logic [3:0] op);
        logic multi;
        case (op)
            ALU_MULT, ALU_AV: multi = 1'b1;
            default:          multi = 1'b0;
        endcase
        return multi;
    endfunction

endpackage

// File: rtl/decode_execute_reg_exec_latency_ctr.sv
// Execute-stage occupancy tracker: a two-state FSM with a 2-bit
// down-counter that keeps a multi-cycle operation resident in execute.
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   flush           bubble being loaded into execute (returns to IDLE)
//   load            decode/execute register is capturing a new instruction
//   load_op         ALU code of the instruction being captured
//   resident_valid  a real (non-bubble) instruction sits in execute
//   multi_stall     multi-cycle op still has cycles to go
//   result_valid    final execute cycle of the resident instruction
//   busy            execute register must hold its contents
module exec_latency_ctr
    import decode_execute_reg_pkg::*;
#(
    parameter int unsigned MULT_LAT = MULT_LAT_DEF,
    parameter int unsigned AV_LAT   = AV_LAT_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       flush,
    input  logic       load,
    input  logic [3:0] load_op,
    input  logic       resident_valid,
    output logic       multi_stall,
    output logic       result_valid,
    output logic       busy
);

    // The counter holds the cycles remaining after the current one
    localparam logic [1:0] MULT_CNT = 2'(MULT_LAT - 1);
    localparam logic [1:0] AV_CNT   = 2'(AV_LAT - 1);

    ex_state_e  state_r;
    logic [1:0] cnt_r;
    logic [1:0] start_cnt_s;
    logic       start_multi_s;

    // Initial count for a multi-cycle op being captured this edge
    always_comb begin
        start_cnt_s   = 2'd0;
        start_multi_s = load & alu_op_multi(load_op);
        case (load_op)
            ALU_MULT: start_cnt_s = MULT_CNT;
            ALU_AV:   start_cnt_s = AV_CNT;
            default:  start_cnt_s = 2'd0;
        endcase
    end

    // Occupancy FSM and down-counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= EX_IDLE;
            cnt_r   <= 2'd0;
        end else if (flush) begin
            state_r <= EX_IDLE;
            cnt_r   <= 2'd0;
        end else begin
            case (state_r)
                EX_IDLE: begin
                    if (start_multi_s) begin
                        state_r <= EX_MULTI;
                        cnt_r   <= start_cnt_s;
                    end else begin
                        state_r <= EX_IDLE;
                        cnt_r   <= 2'd0;
                    end
                end
                EX_MULTI: begin
                    if (cnt_r != 2'd0) begin
                        cnt_r <= cnt_r - 2'd1;
                    end else if (start_multi_s) begin
                        // back-to-back multi-cycle op: no idle cycle
                        state_r <= EX_MULTI;
                        cnt_r   <= start_cnt_s;
                    end else begin
                        state_r <= EX_IDLE;
                        cnt_r   <= 2'd0;
                    end
                end
                default: begin
                    state_r <= EX_IDLE;
                    cnt_r   <= 2'd0;
                end
            endcase
        end
    end

    // Status flags decoded straight from the state and counter registers
    always_comb begin
        multi_stall  = (state_r == EX_MULTI) && (cnt_r != 2'd0);
        busy         = multi_stall;
        if (state_r == EX_MULTI) begin
            result_valid = (cnt_r == 2'd0);
        end else begin
            result_valid = resident_valid;
        end
    end

endmodule

// File: rtl/decode_execute_reg.sv
// Decode/execute pipeline register with multi-cycle execute support.
// Captures decode control and data into execute, inserts bubbles on
// flush, holds on stall or while a MULT/AV is still executing, squashes
// undefined ALU codes, and reports execute occupancy status.
// Ports:
//   clk, rst_n                       clock, asynchronous active-low reset
//   StallD, FlushE                   hazard-unit hold / bubble request
//   *D inputs                        decode-stage control, data, reg numbers
//   *E outputs                       registered execute-stage copies
//   MultiStallE                      multi-cycle op still executing
//   ResultValidE                     final execute cycle of resident instr
//   IllegalOpE                       one-cycle pulse on undefined ALU code
module decode_execute_reg
    import decode_execute_reg_pkg::*;
#(
    parameter int unsigned MULT_LAT = MULT_LAT_DEF,
    parameter int unsigned AV_LAT   = AV_LAT_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        StallD,
    input  logic        FlushE,
    input  logic        ALUSrcD,
    input  logic        MemToRegD,
    input  logic        RegWriteD,
    input  logic        PlusOneD,
    input  logic        BranchD,
    input  logic        PCSrcD,
    input  logic [3:0]  ALUControlD,
    input  logic [31:0] RD1D,
    input  logic [31:0] RD2D,
    input  logic [31:0] ExtImmD,
    input  logic [3:0]  RA1D,
    input  logic [3:0]  RA2D,
    input  logic [3:0]  WA3D,
    output logic        ALUSrcE,
    output logic        MemToRegE,
    output logic        RegWriteE,
    output logic        PlusOneE,
    output logic        BranchE,
    output logic        PCSrcE,
    output logic [3:0]  ALUControlE,
    output logic [31:0] RD1E,
    output logic [31:0] RD2E,
    output logic [31:0] ExtImmE,
    output logic [3:0]  RA1E,
    output logic [3:0]  RA2E,
    output logic [3:0]  WA3E,
    output logic        MultiStallE,
    output logic        ResultValidE,
    output logic        IllegalOpE
);

    de_fields_t d_fields_s;
    de_fields_t ex_nxt_s;
    de_fields_t ex_r;
    logic       valid_nxt_s;
    logic       valid_r;
    logic       illegal_nxt_s;
    logic       illegal_r;
    logic       busy_s;
    logic       load_s;

    assign d_fields_s = '{
        alu_src:     ALUSrcD,
        mem_to_reg:  MemToRegD,
        reg_write:   RegWriteD,
        plus_one:    PlusOneD,
        branch:      BranchD,
        pc_src:      PCSrcD,
        alu_control: ALUControlD,
        rd1:         RD1D,
        rd2:         RD2D,
        ext_imm:     ExtImmD,
        ra1:         RA1D,
        ra2:         RA2D,
        wa3:         WA3D
    };

    // Flush beats the multi-cycle hold, which beats StallD
    assign load_s = ~FlushE & ~busy_s & ~StallD;

    exec_latency_ctr #(
        .MULT_LAT (MULT_LAT),
        .AV_LAT   (AV_LAT)
    ) u_exec_latency_ctr (
        .clk            (clk),
        .rst_n          (rst_n),
        .flush          (FlushE),
        .load           (load_s),
        .load_op        (ALUControlD),
        .resident_valid (valid_r),
        .multi_stall    (MultiStallE),
        .result_valid   (ResultValidE),
        .busy           (busy_s)
    );

    // Next execute contents: bubble, hold, or capture (squashing undefined ops)
    always_comb begin
        ex_nxt_s      = ex_r;
        valid_nxt_s   = valid_r;
        illegal_nxt_s = 1'b0;
        if (FlushE) begin
            ex_nxt_s    = DE_BUBBLE;
            valid_nxt_s = 1'b0;
        end else if (load_s) begin
            ex_nxt_s = d_fields_s;
            if (alu_op_legal(ALUControlD)) begin
                valid_nxt_s = 1'b1;
            end else begin
                // Undefined op: keep data for debug, kill every side effect.
                // It is not a real instruction, so no result is reported.
                ex_nxt_s.alu_control = ALU_NOP;
                ex_nxt_s.reg_write   = 1'b0;
                ex_nxt_s.mem_to_reg  = 1'b0;
                ex_nxt_s.branch      = 1'b0;
                ex_nxt_s.pc_src      = 1'b0;
                valid_nxt_s          = 1'b0;
                illegal_nxt_s        = 1'b1;
            end
        end else begin
            ex_nxt_s    = ex_r;
            valid_nxt_s = valid_r;
        end
    end

    // Execute-stage register bank
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_r      <= DE_BUBBLE;
            valid_r   <= 1'b0;
            illegal_r <= 1'b0;
        end else begin
            ex_r      <= ex_nxt_s;
            valid_r   <= valid_nxt_s;
            illegal_r <= illegal_nxt_s;
        end
    end

    assign ALUSrcE     = ex_r.alu_src;
    assign MemToRegE   = ex_r.mem_to_reg;
    assign RegWriteE   = ex_r.reg_write;
    assign PlusOneE    = ex_r.plus_one;
    assign BranchE     = ex_r.branch;
    assign PCSrcE      = ex_r.pc_src;
    assign ALUControlE = ex_r.alu_control;
    assign RD1E        = ex_r.rd1;
    assign RD2E        = ex_r.rd2;
    assign ExtImmE     = ex_r.ext_imm;
    assign RA1E        = ex_r.ra1;
    assign RA2E        = ex_r.ra2;
    assign WA3E        = ex_r.wa3;
    assign IllegalOpE  = illegal_r;

endmodule

// File: tb/tb_decode_execute_reg.sv
// Self-checking bench for decode_execute_reg (default MULT_LAT=3, AV_LAT=2).
// A reference model tracks the resident instruction and how many execute
// cycles it still needs; expected outputs are derived from that.
module tb_decode_execute_reg;
    import decode_execute_reg_pkg::*;

    localparam int MULT_LAT = 3;
    localparam int AV_LAT   = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        StallD = 1'b0, FlushE = 1'b0;
    logic        ALUSrcD = 1'b0, MemToRegD = 1'b0, RegWriteD = 1'b0;
    logic        PlusOneD = 1'b0, BranchD = 1'b0, PCSrcD = 1'b0;
    logic [3:0]  ALUControlD = 4'd0;
    logic [31:0] RD1D = 32'd0, RD2D = 32'd0, ExtImmD = 32'd0;
    logic [3:0]  RA1D = 4'd0, RA2D = 4'd0, WA3D = 4'd0;
    logic        ALUSrcE, MemToRegE, RegWriteE, PlusOneE, BranchE, PCSrcE;
    logic [3:0]  ALUControlE;
    logic [31:0] RD1E, RD2E, ExtImmE;
    logic [3:0]  RA1E, RA2E, WA3E;
    logic        MultiStallE, ResultValidE, IllegalOpE;

    decode_execute_reg #(.MULT_LAT(MULT_LAT), .AV_LAT(AV_LAT)) dut (
        .clk(clk), .rst_n(rst_n), .StallD(StallD), .FlushE(FlushE),
        .ALUSrcD(ALUSrcD), .MemToRegD(MemToRegD), .RegWriteD(RegWriteD),
        .PlusOneD(PlusOneD), .BranchD(BranchD), .PCSrcD(PCSrcD),
        .ALUControlD(ALUControlD), .RD1D(RD1D), .RD2D(RD2D), .ExtImmD(ExtImmD),
        .RA1D(RA1D), .RA2D(RA2D), .WA3D(WA3D),
        .ALUSrcE(ALUSrcE), .MemToRegE(MemToRegE), .RegWriteE(RegWriteE),
        .PlusOneE(PlusOneE), .BranchE(BranchE), .PCSrcE(PCSrcE),
        .ALUControlE(ALUControlE), .RD1E(RD1E), .RD2E(RD2E), .ExtImmE(ExtImmE),
        .RA1E(RA1E), .RA2E(RA2E), .WA3E(WA3E),
        .MultiStallE(MultiStallE), .ResultValidE(ResultValidE), .IllegalOpE(IllegalOpE)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model state
    logic [117:0] m_vec;    // expected *E fields, same order as dut_vec
    logic         m_valid;  // a real instruction is resident
    int           m_rem;    // execute cycles still owed, counting the current one
    logic         m_ill;

    logic [117:0] dut_vec;
    assign dut_vec = {ALUSrcE, MemToRegE, RegWriteE, PlusOneE, BranchE, PCSrcE,
                      ALUControlE, RD1E, RD2E, ExtImmE, RA1E, RA2E, WA3E};
    logic [120:0] act_all;
    assign act_all = {dut_vec, MultiStallE, ResultValidE, IllegalOpE};

    function automatic logic [120:0] exp_all();
        return {m_vec, (m_rem > 1), (m_valid && m_rem == 1), m_ill};
    endfunction

    function automatic int op_lat(input logic [3:0] op);
        if (op == 4'd3) return MULT_LAT;
        if (op == 4'd5) return AV_LAT;
        return 1;
    endfunction

    task automatic model_reset();
        m_vec = '0; m_valid = 1'b0; m_rem = 0; m_ill = 1'b0;
    endtask

    // Behaviour at one rising edge, from the inputs presented to it
    task automatic model_edge();
        if (!rst_n) begin
            model_reset();
        end else if (FlushE) begin
            model_reset();
        end else if (m_rem > 1) begin
            m_rem = m_rem - 1;
            m_ill = 1'b0;
        end else if (StallD) begin
            m_ill = 1'b0;
        end else if (ALUControlD <= 4'd5) begin
            m_vec = {ALUSrcD, MemToRegD, RegWriteD, PlusOneD, BranchD, PCSrcD,
                     ALUControlD, RD1D, RD2D, ExtImmD, RA1D, RA2D, WA3D};
            m_valid = 1'b1; m_rem = op_lat(ALUControlD); m_ill = 1'b0;
        end else begin
            m_vec = {ALUSrcD, 1'b0, 1'b0, PlusOneD, 1'b0, 1'b0,
                     4'd0, RD1D, RD2D, ExtImmD, RA1D, RA2D, WA3D};
            m_valid = 1'b0; m_rem = 1; m_ill = 1'b1;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic set_d(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [3:0] wa, input logic [5:0] ctl);
        {ALUSrcD, MemToRegD, RegWriteD, PlusOneD, BranchD, PCSrcD} = ctl;
        ALUControlD = op; RD1D = a; RD2D = b; ExtImmD = a ^ b;
        RA1D = wa + 4'd1; RA2D = wa + 4'd2; WA3D = wa;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; StallD = 1'b0; FlushE = 1'b0;
        set_d(4'd1, 32'hDEAD_BEEF, 32'h1234_5678, 4'd9, 6'b111111);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if (act_all !== 121'd0) begin
            n_fail++; $display("FAIL reset_state got=%h exp=0", act_all);
        end
        @(negedge clk); rst_n = 1'b1;
    endtask

    task automatic test_load_add();
        set_d(4'd1, 32'd5, 32'd7, 4'd3, 6'b001000);
        tick();
        n_cmp++;
        if (ALUControlE !== 4'd1 || RD1E !== 32'd5 || RD2E !== 32'd7 || WA3E !== 4'd3 ||
            ResultValidE !== 1'b1 || MultiStallE !== 1'b0) begin
            n_fail++; $display("FAIL load_add got op=%0d rd1=%0d rd2=%0d wa=%0d rv=%b ms=%b exp 1/5/7/3/1/0",
                               ALUControlE, RD1E, RD2E, WA3E, ResultValidE, MultiStallE);
        end
        n_cmp++;
        if (act_all !== exp_all()) begin
            n_fail++; $display("FAIL load_add_model got=%h exp=%h", act_all, exp_all());
        end
    endtask

    task automatic test_mult();
        logic [2:0] ms_seq, rv_seq;
        set_d(4'd3, 32'd11, 32'd13, 4'd6, 6'b001000);
        for (int i = 0; i < 3; i++) begin
            tick();
            ms_seq[i] = MultiStallE; rv_seq[i] = ResultValidE;
            n_cmp++;
            if (act_all !== exp_all()) begin
                n_fail++; $display("FAIL mult_cycle%0d got=%h exp=%h", i, act_all, exp_all());
            end
            // unrelated decode input must be ignored while MULT is resident
            set_d(4'd1, 32'd99, 32'd98, 4'd1, 6'b001000);
        end
        n_cmp++;
        if (ms_seq !== 3'b011 || rv_seq !== 3'b100 || RD1E !== 32'd11) begin
            n_fail++; $display("FAIL mult_hold got ms=%b rv=%b rd1=%0d exp ms=011 rv=100 rd1=11",
                               ms_seq, rv_seq, RD1E);
        end
        tick();
        n_cmp++;
        if (RD1E !== 32'd99 || act_all !== exp_all()) begin
            n_fail++; $display("FAIL mult_after got=%h exp=%h", act_all, exp_all());
        end
    endtask

    task automatic test_flush_mult();
        set_d(4'd3, 32'd21, 32'd22, 4'd7, 6'b001000);
        tick();
        tick();
        FlushE = 1'b1;
        tick();
        FlushE = 1'b0;
        n_cmp++;
        if (ALUControlE !== 4'd0 || MultiStallE !== 1'b0 || ResultValidE !== 1'b0 || dut_vec !== 118'd0) begin
            n_fail++; $display("FAIL flush_mult got vec=%h ms=%b rv=%b exp all 0", dut_vec, MultiStallE, ResultValidE);
        end
        set_d(4'd2, 32'd1, 32'd2, 4'd4, 6'b001000);
        tick();
        n_cmp++;
        if (act_all !== exp_all() || ResultValidE !== 1'b1) begin
            n_fail++; $display("FAIL flush_then_load got=%h exp=%h", act_all, exp_all());
        end
    endtask

    task automatic test_illegal();
        set_d(4'hF, 32'd3, 32'd4, 4'd5, 6'b111111);
        tick();
        n_cmp++;
        if (ALUControlE !== 4'd0 || RegWriteE !== 1'b0 || IllegalOpE !== 1'b1 || RD1E !== 32'd3) begin
            n_fail++; $display("FAIL illegal_capture got op=%0d rw=%b ill=%b rd1=%0d exp 0/0/1/3",
                               ALUControlE, RegWriteE, IllegalOpE, RD1E);
        end
        n_cmp++;
        if (act_all !== exp_all()) begin
            n_fail++; $display("FAIL illegal_model got=%h exp=%h", act_all, exp_all());
        end
        StallD = 1'b1;
        tick();
        StallD = 1'b0;
        n_cmp++;
        if (IllegalOpE !== 1'b0 || act_all !== exp_all()) begin
            n_fail++; $display("FAIL illegal_pulse_len got ill=%b exp 0", IllegalOpE);
        end
    endtask

    task automatic test_stall_flush();
        set_d(4'd2, 32'd40, 32'd41, 4'd8, 6'b001000);
        tick();
        StallD = 1'b1;
        set_d(4'd1, 32'd50, 32'd51, 4'd2, 6'b001000);
        tick();
        n_cmp++;
        if (ALUControlE !== 4'd2 || RD1E !== 32'd40 || act_all !== exp_all()) begin
            n_fail++; $display("FAIL stall_hold got op=%0d rd1=%0d exp 2/40", ALUControlE, RD1E);
        end
        FlushE = 1'b1;
        tick();
        StallD = 1'b0; FlushE = 1'b0;
        n_cmp++;
        if (ALUControlE !== 4'd0 || dut_vec !== 118'd0 || ResultValidE !== 1'b0) begin
            n_fail++; $display("FAIL stall_flush got vec=%h rv=%b exp 0", dut_vec, ResultValidE);
        end
    endtask

    task automatic test_back_to_back();
        logic [5:0] ms_seq, rv_seq;
        set_d(4'd3, 32'd7, 32'd8, 4'd1, 6'b001000);
        for (int i = 0; i < 6; i++) begin
            tick();
            ms_seq[i] = MultiStallE; rv_seq[i] = ResultValidE;
            n_cmp++;
            if (act_all !== exp_all()) begin
                n_fail++; $display("FAIL b2b_cycle%0d got=%h exp=%h", i, act_all, exp_all());
            end
        end
        n_cmp++;
        if (ms_seq !== 6'b011011 || rv_seq !== 6'b100100) begin
            n_fail++; $display("FAIL b2b_pattern got ms=%b rv=%b exp ms=011011 rv=100100", ms_seq, rv_seq);
        end
        set_d(4'd0, 32'd0, 32'd0, 4'd0, 6'b000000);
        repeat (3) tick();
    endtask

    task automatic test_async_reset_av();
        set_d(4'd5, 32'd70, 32'd71, 4'd12, 6'b101101);
        tick();
        n_cmp++;
        if (MultiStallE !== 1'b1 || act_all !== exp_all()) begin
            n_fail++; $display("FAIL av_start got=%h exp=%h", act_all, exp_all());
        end
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        n_cmp++;
        if (act_all !== 121'd0) begin
            n_fail++; $display("FAIL async_reset_av got=%h exp=0", act_all);
        end
        @(negedge clk); rst_n = 1'b1;
        set_d(4'd4, 32'd80, 32'd81, 4'd13, 6'b001000);
        tick();
        n_cmp++;
        if (act_all !== exp_all() || ResultValidE !== 1'b1) begin
            n_fail++; $display("FAIL reset_release_load got=%h exp=%h", act_all, exp_all());
        end
    endtask

    task automatic test_random();
        int r;
        for (int i = 0; i < 400; i++) begin
            r = $urandom_range(0, 15);
            set_d((r < 12) ? 4'(r % 6) : 4'(r), $urandom, $urandom,
                  4'($urandom_range(0, 15)), 6'($urandom_range(0, 63)));
            ExtImmD = $urandom;
            StallD = ($urandom_range(0, 3) == 0);
            FlushE = ($urandom_range(0, 9) == 0);
            tick();
            n_cmp++;
            if (act_all !== exp_all()) begin
                n_fail++; $display("FAIL random_%0d got=%h exp=%h", i, act_all, exp_all());
            end
        end
        StallD = 1'b0; FlushE = 1'b0;
    endtask

    initial begin
        model_reset();
        test_reset();
        test_load_add();
        test_mult();
        test_flush_mult();
        test_illegal();
        test_stall_flush();
        test_back_to_back();
        test_async_reset_av();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
